mode_controller: RTL and testbench

MODE_CONTROLLER -- requirements
Module: Mode_Controller

---
 rtl/mode_controller_pkg.sv | 33 +++
 rtl/mode_controller_if.sv | 38 +++
 rtl/mode_controller_edge_detect.sv | 32 +++
 rtl/mode_controller.sv | 133 +++++++++++++
 tb/tb_mode_controller.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/mode_controller_pkg.sv
// ============================================================================
// Module   : mode_controller_pkg
// Purpose  : Shared constants and helpers for the mode controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mode_controller_pkg;

  // o_State value meaning "no active mode, idle animation running";
  // active mode k is encoded as the plain value k (switch index + 1).
  localparam int STATE_INIT = 0;

  // Width of the one-hot segment drive.
  localparam int SEG_OUT_W  = 7;

  // Segment index register width (ring length is at most 7).
  localparam int SEG_IDX_W  = 3;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width needed to hold values 0..max_val, never less than one bit.
  function automatic int width_for(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mode_controller_if.sv
// ============================================================================
// Module   : mode_controller_if
// Purpose  : Switch input and state/segment output bundle of the controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mode_controller_if #(
  parameter int g_NUM_MODES = 3
) ();
  import mode_controller_pkg::*;

  localparam int STATE_W = width_for(g_NUM_MODES);

  logic [g_NUM_MODES:0]   i_Switches;
  logic [STATE_W-1:0]     o_State;
  logic [SEG_OUT_W-1:0]   o_Segments;
  logic                   o_Mode_Change;

  // Master drives the switches and observes the controller.
  modport master (
    output i_Switches,
    input  o_State,
    input  o_Segments,
    input  o_Mode_Change
  );

  // Slave is the controller itself.
  modport slave (
    input  i_Switches,
    output o_State,
    output o_Segments,
    output o_Mode_Change
  );

endinterface

`default_nettype wire

// File: rtl/mode_controller_edge_detect.sv
// ============================================================================
// Module   : mode_controller_edge_detect
// Purpose  : Width-generic input register plus falling-edge (release) vector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mode_controller_edge_detect #(
  parameter int g_WIDTH = 4
) (
  input  wire logic               i_Clk,
  input  wire logic               i_Reset,
  input  wire logic [g_WIDTH-1:0] i_Data,
  output logic      [g_WIDTH-1:0] o_Falling
);

  logic [g_WIDTH-1:0] data_q;

  // Previous-cycle copy; cleared on reset so nothing looks released right after.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      data_q <= '0;
    end else begin
      data_q <= i_Data;
    end
  end

  assign o_Falling = data_q & ~i_Data;

endmodule

`default_nettype wire

// File: rtl/mode_controller.sv
// ============================================================================
// Module   : mode_controller
// Purpose  : Selects one of g_NUM_MODES modes on switch release, runs a
//            segment animation while idle and returns to idle after a
//            sustained press of the hold switch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mode_controller
  import mode_controller_pkg::*;
#(
  parameter int g_NUM_MODES       = 3,
  parameter int g_NUM_SEGMENTS    = 6,
  parameter int g_ANIMATION_DELAY = 25000000 / 6,
  parameter int g_RESET_DELAY     = 25000000 * 3,
  parameter int g_DIRECT_SWITCH   = 1
) (
  input wire logic          i_Clk,
  input wire logic          i_Reset,
  mode_controller_if.slave  bus
);

  localparam int STATE_W = width_for(g_NUM_MODES);
  localparam int DELAY_W = width_for(max2(g_ANIMATION_DELAY, g_RESET_DELAY));

  logic [STATE_W-1:0]   state_q,  state_d;
  logic [SEG_IDX_W-1:0] seg_q,    seg_d;
  logic [DELAY_W-1:0]   delay_q,  delay_d;
  logic                 change_q, change_d;

  logic [g_NUM_MODES:0] w_falling;
  logic                 w_hold;
  logic                 w_rel_any;
  logic [STATE_W-1:0]   w_rel_mode;
  logic                 w_illegal;

  mode_controller_edge_detect #(
    .g_WIDTH (g_NUM_MODES + 1)
  ) u_edge (
    .i_Clk     (i_Clk),
    .i_Reset   (i_Reset),
    .i_Data    (bus.i_Switches),
    .o_Falling (w_falling)
  );

  assign w_hold = bus.i_Switches[g_NUM_MODES];

  // Lowest-index released mode switch wins; result is the mode number (index+1).
  always_comb begin
    w_rel_any  = 1'b0;
    w_rel_mode = '0;
    for (int n = g_NUM_MODES - 1; n >= 0; n--) begin
      if (w_falling[n]) begin
        w_rel_any  = 1'b1;
        w_rel_mode = STATE_W'(n + 1);
      end
    end
  end

  // Out-of-range state codes only exist when the state width has spare values.
  generate
    if (((1 << STATE_W) - 1) > g_NUM_MODES) begin : g_illegal_check
      assign w_illegal = (state_q > STATE_W'(g_NUM_MODES));
    end else begin : g_no_illegal
      assign w_illegal = 1'b0;
    end
  endgenerate

  // Next-state: idle animation, mode selection, hold-to-return and direct switching.
  always_comb begin
    state_d  = state_q;
    seg_d    = seg_q;
    delay_d  = delay_q;
    change_d = 1'b0;
    if (w_illegal) begin
      state_d  = STATE_W'(STATE_INIT);
      seg_d    = '0;
      delay_d  = '0;
      change_d = 1'b1;
    end else if (state_q == STATE_W'(STATE_INIT)) begin
      if (w_rel_any) begin
        // Segment index freezes; the counter restarts for hold timing.
        state_d  = w_rel_mode;
        delay_d  = '0;
        change_d = 1'b1;
      end else if (delay_q == DELAY_W'(g_ANIMATION_DELAY)) begin
        delay_d = '0;
        seg_d   = (seg_q == SEG_IDX_W'(g_NUM_SEGMENTS - 1)) ? '0 : seg_q + 1'b1;
      end else begin
        delay_d = delay_q + 1'b1;
      end
    end else if (w_hold) begin
      // Hold has priority over any mode release while active.
      if (delay_q == DELAY_W'(g_RESET_DELAY)) begin
        state_d  = STATE_W'(STATE_INIT);
        seg_d    = '0;
        delay_d  = '0;
        change_d = 1'b1;
      end else begin
        delay_d = delay_q + 1'b1;
      end
    end else begin
      delay_d = '0;
      if ((g_DIRECT_SWITCH != 0) && w_rel_any && (w_rel_mode != state_q)) begin
        state_d  = w_rel_mode;
        change_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q  <= STATE_W'(STATE_INIT);
      seg_q    <= '0;
      delay_q  <= '0;
      change_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      seg_q    <= seg_d;
      delay_q  <= delay_d;
      change_q <= change_d;
    end
  end

  assign bus.o_State       = state_q;
  assign bus.o_Segments    = SEG_OUT_W'(1) << seg_q;
  assign bus.o_Mode_Change = change_q;

endmodule

`default_nettype wire

// File: tb/tb_mode_controller.sv
// ============================================================================
// Module   : tb_mode_controller
// Purpose  : Self-checking bench; two controllers (direct switching on/off)
//            driven by identical switches and compared with a behavioural
//            model each cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mode_controller;

  localparam int NM   = 3;
  localparam int NSEG = 6;
  localparam int ANIM = 3;
  localparam int RDLY = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  mode_controller_if #(.g_NUM_MODES(NM)) bus1 ();
  mode_controller_if #(.g_NUM_MODES(NM)) bus0 ();

  mode_controller #(
    .g_NUM_MODES(NM), .g_NUM_SEGMENTS(NSEG), .g_ANIMATION_DELAY(ANIM),
    .g_RESET_DELAY(RDLY), .g_DIRECT_SWITCH(1)
  ) dut_direct (
    .i_Clk(clk), .i_Reset(rst), .bus(bus1)
  );

  mode_controller #(
    .g_NUM_MODES(NM), .g_NUM_SEGMENTS(NSEG), .g_ANIMATION_DELAY(ANIM),
    .g_RESET_DELAY(RDLY), .g_DIRECT_SWITCH(0)
  ) dut_nodirect (
    .i_Clk(clk), .i_Reset(rst), .bus(bus0)
  );

  always #5 clk = ~clk;

  // Reference model state, index 1 = direct switching, 0 = no direct switching.
  int         m_state [2];
  int         m_idle  [2];   // cycles spent animating since the ring restarted
  int         m_seg   [2];
  int         m_run   [2];   // consecutive hold-high cycles while active
  int         m_mc    [2];
  logic [3:0] m_prev  [2];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input logic [3:0] sw, input bit r);
    int low;
    low = -1;
    for (int n = NM - 1; n >= 0; n--)
      if (m_prev[k][n] && !sw[n]) low = n;
    m_mc[k] = 0;
    if (r) begin
      m_state[k] = 0; m_idle[k] = 0; m_seg[k] = 0; m_run[k] = 0; m_prev[k] = '0;
      return;
    end
    if (m_state[k] == 0) begin
      if (low >= 0) begin
        m_state[k] = low + 1; m_mc[k] = 1; m_run[k] = 0;
      end else begin
        m_idle[k]++;
        m_seg[k] = (m_idle[k] / (ANIM + 1)) % NSEG;
      end
    end else if (sw[NM]) begin
      m_run[k]++;
      if (m_run[k] == RDLY + 1) begin
        m_state[k] = 0; m_mc[k] = 1; m_idle[k] = 0; m_seg[k] = 0; m_run[k] = 0;
      end
    end else begin
      m_run[k] = 0;
      if (k == 1 && low >= 0 && low + 1 != m_state[k]) begin
        m_state[k] = low + 1; m_mc[k] = 1;
      end
    end
    m_prev[k] = sw;
  endtask

  task automatic step(input logic [3:0] sw, input bit r);
    @(negedge clk);
    bus1.i_Switches = sw;
    bus0.i_Switches = sw;
    rst = r;
    @(posedge clk);
    model_step(1, sw, r);
    model_step(0, sw, r);
    #1;
    check("state_d1", int'(bus1.o_State),       m_state[1]);
    check("seg_d1",   int'(bus1.o_Segments),    1 << m_seg[1]);
    check("mc_d1",    int'(bus1.o_Mode_Change), m_mc[1]);
    check("state_d0", int'(bus0.o_State),       m_state[0]);
    check("seg_d0",   int'(bus0.o_Segments),    1 << m_seg[0]);
    check("mc_d0",    int'(bus0.o_Mode_Change), m_mc[0]);
  endtask

  task automatic repeat_step(input logic [3:0] sw, input int n);
    for (int i = 0; i < n; i++) step(sw, 1'b0);
  endtask

  initial begin
    logic [3:0] sw;
    bus1.i_Switches = '0;
    bus0.i_Switches = '0;
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_idle[k] = 0; m_seg[k] = 0;
      m_run[k] = 0; m_mc[k] = 0; m_prev[k] = '0;
    end

    // Reset state
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    check("rst_state", int'(bus1.o_State), 0);
    check("rst_seg",   int'(bus1.o_Segments), 1);
    check("rst_mc",    int'(bus1.o_Mode_Change), 0);

    // Idle animation
    repeat_step(4'b0000, 30);

    // Press/release switch 1 in INIT -> mode 2
    repeat_step(4'b0010, 2);
    step(4'b0000, 1'b0);
    check("sel_mode2", int'(bus1.o_State), 2);
    check("sel_pulse", int'(bus1.o_Mode_Change), 1);
    step(4'b0000, 1'b0);
    check("pulse_once", int'(bus1.o_Mode_Change), 0);

    // Hold 5 cycles then release -> stay in mode 2
    repeat_step(4'b1000, 5);
    step(4'b0000, 1'b0);
    check("hold5_stay", int'(bus1.o_State), 2);

    // Hold 6 cycles -> INIT
    repeat_step(4'b1000, 6);
    check("hold6_init", int'(bus1.o_State), 0);
    check("hold6_seg",  int'(bus1.o_Segments), 1);
    step(4'b0000, 1'b0);

    // Simultaneous release of switches 0 and 2 -> mode 1
    step(4'b0101, 1'b0);
    step(4'b0000, 1'b0);
    check("low_wins", int'(bus1.o_State), 1);

    // Direct switching from mode 1 via switch 2
    step(4'b0100, 1'b0);
    step(4'b0000, 1'b0);
    check("direct_on",  int'(bus1.o_State), 3);
    check("direct_off", int'(bus0.o_State), 1);

    // Back to INIT, enter mode 2, reset at hold cycle 4
    repeat_step(4'b1000, 6);
    step(4'b0000, 1'b0);
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);
    repeat_step(4'b1000, 3);
    step(4'b1000, 1'b1);
    check("midhold_rst_state", int'(bus1.o_State), 0);
    check("midhold_rst_seg",   int'(bus1.o_Segments), 1);
    check("midhold_rst_mc",    int'(bus1.o_Mode_Change), 0);
    step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
    repeat_step(4'b1000, 5);
    check("full_hold_needed", int'(bus1.o_State), 1);
    step(4'b1000, 1'b0);
    check("full_hold_init", int'(bus1.o_State), 0);

    // Randomized traffic: sticky hold switch, occasional mode-bit changes and resets
    sw = 4'b0000;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 5) == 0) sw[3] = ~sw[3];
      if ($urandom_range(0, 2) == 0) sw[2:0] = 3'($urandom);
      step(sw, ($urandom_range(0, 149) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
